// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: two requesters (A = ALU, B = load/mul-div) and the
// register-file write port plus the per-register pending scoreboard.
interface wb_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        regWrite;
  logic [4:0]  rWriteAddress;
  logic [31:0] rWriteValue;
  logic        wb_src;
  logic [31:0] pending;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, regWrite, rWriteAddress, rWriteValue, wb_src, pending
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, regWrite, rWriteAddress, rWriteValue, wb_src, pending
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: A writes directly, B writes go through a
// small FIFO whose head preempts A once it has waited STARVE_LIMIT cycles.

// One B-queue slot; also reports which register it is holding a write for.
module wb_arbiter_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [4:0]  addr_in,
  input  logic [31:0] data_in,
  output logic [4:0]  addr,
  output logic [31:0] data,
  output logic [31:0] mask
);
  logic vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld  <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      addr <= addr_in;
      data <= data_in;
    end else if (clear) begin
      vld  <= 1'b0;
    end
  end

  always_comb begin
    mask = '0;
    if (vld) mask[addr] = 1'b1;
  end
endmodule

module wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count;
  logic [3:0]                  age;
  logic [DEPTH-1:0]            slot_load, slot_clr;
  logic [DEPTH-1:0][4:0]       slot_addr;
  logic [DEPTH-1:0][31:0]      slot_data;
  logic [DEPTH-1:0][31:0]      slot_mask;
  logic                        empty, full, starved, push, pop;
  logic                        a_grant, b_grant;
  logic [4:0]                  head_addr;
  logic [31:0]                 head_data;
  logic                        reg_write, w_src;
  logic [4:0]                  w_addr;
  logic [31:0]                 w_data;
  logic [31:0]                 pend;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign starved   = !empty && (age == 4'(STARVE_LIMIT));
  assign head_addr = slot_addr[rd_ptr];
  assign head_data = slot_data[rd_ptr];

  // B only competes from the registered head, so a fresh push waits a cycle.
  assign b_grant = !empty && (starved || !bus.a_valid);
  assign a_grant = bus.a_valid && !b_grant;
  assign push    = bus.b_valid && !full;
  assign pop     = b_grant;

  assign bus.a_ready = !starved;
  assign bus.b_ready = !full;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_slot
      assign slot_load[i] = push && (wr_ptr == PW'(i));
      assign slot_clr[i]  = pop  && (rd_ptr == PW'(i));
      wb_arbiter_slot u_slot (
        .clk     (clk),
        .rst     (rst),
        .load    (slot_load[i]),
        .clear   (slot_clr[i]),
        .addr_in (bus.b_addr),
        .data_in (bus.b_data),
        .addr    (slot_addr[i]),
        .data    (slot_data[i]),
        .mask    (slot_mask[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Age tracks how long the current head has been passed over.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          age <= '0;
    else if (empty || pop)             age <= '0;
    else if (age != 4'(STARVE_LIMIT))  age <= age + 4'd1;
  end

  // Output stage; address-0 grants are consumed but never write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write <= 1'b0;
      w_addr    <= '0;
      w_data    <= '0;
      w_src     <= 1'b0;
    end else if (a_grant) begin
      reg_write <= (bus.a_addr != 5'd0);
      w_addr    <= bus.a_addr;
      w_data    <= bus.a_data;
      w_src     <= 1'b0;
    end else if (b_grant) begin
      reg_write <= (head_addr != 5'd0);
      w_addr    <= head_addr;
      w_data    <= head_data;
      w_src     <= 1'b1;
    end else begin
      reg_write <= 1'b0;
    end
  end

  always_comb begin
    pend = '0;
    for (int k = 0; k < DEPTH; k++) pend |= slot_mask[k];
    if (reg_write && w_src) pend[w_addr] = 1'b1;
    pend[0] = 1'b0;
  end

  assign bus.pending       = pend;
  assign bus.regWrite      = reg_write;
  assign bus.rWriteAddress = w_addr;
  assign bus.rWriteValue   = w_data;
  assign bus.wb_src        = w_src;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes are queued in grant order and
// a negedge monitor matches every regWrite against that queue.
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passed = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        src;
  } wr_t;
  wr_t expq[$];

  wb_arbiter_if bus();
  wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic exp_wr(input logic [4:0] a, input logic [31:0] d, input logic s);
    wr_t w;
    w.addr = a; w.data = d; w.src = s;
    expq.push_back(w);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst && bus.regWrite) begin
      if (expq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got addr %0d data %0h src %0d want none",
                 bus.rWriteAddress, bus.rWriteValue, bus.wb_src);
      end else begin
        wr_t w;
        w = expq.pop_front();
        chk("write", {bus.wb_src, bus.rWriteAddress, bus.rWriteValue},
            {w.src, w.addr, w.data});
      end
    end
  end

  // One cycle: drive at posedge+1, check handshakes at negedge, return at next posedge+1
  task automatic cyc(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                     input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                     input logic ear, input logic ebr, input string nm);
    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
    bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
    @(negedge clk);
    chk({nm, ".a_ready"}, 64'(bus.a_ready), 64'(ear));
    chk({nm, ".b_ready"}, 64'(bus.b_ready), 64'(ebr));
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 1, 1, "idle");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with live-looking inputs that must be ignored
    bus.a_valid = 1; bus.a_addr = 5'd3; bus.a_data = 32'hDEAD;
    bus.b_valid = 1; bus.b_addr = 5'd4; bus.b_data = 32'hBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.regWrite", 64'(bus.regWrite), 0);
    chk("rst.addr", 64'(bus.rWriteAddress), 0);
    chk("rst.value", 64'(bus.rWriteValue), 0);
    chk("rst.wb_src", 64'(bus.wb_src), 0);
    chk("rst.pending", 64'(bus.pending), 0);
    chk("rst.a_ready", 64'(bus.a_ready), 1);
    chk("rst.b_ready", 64'(bus.b_ready), 1);
    @(posedge clk); #1;
    bus.a_valid = 0; bus.b_valid = 0;
    rst = 1;
    idle(1);

    // A only
    exp_wr(5, 32'h1234, 0);
    cyc(1, 5, 32'h1234, 0, 0, 0, 1, 1, "aonly");
    chk("aonly.lat.regWrite", 64'(bus.regWrite), 1);
    chk("aonly.lat.addr", 64'(bus.rWriteAddress), 5);
    chk("aonly.lat.src", 64'(bus.wb_src), 0);
    idle(1);
    chk("aonly.after.regWrite", 64'(bus.regWrite), 0);

    // B only
    exp_wr(7, 32'hCAFE, 1);
    cyc(0, 0, 0, 1, 7, 32'hCAFE, 1, 1, "bonly.c0");
    chk("bonly.c1.pending", 64'(bus.pending), 64'h80);
    chk("bonly.c1.regWrite", 64'(bus.regWrite), 0);
    idle(1);
    chk("bonly.c2.regWrite", 64'(bus.regWrite), 1);
    chk("bonly.c2.src", 64'(bus.wb_src), 1);
    chk("bonly.c2.pending", 64'(bus.pending), 64'h80);
    idle(1);
    chk("bonly.c3.pending", 64'(bus.pending), 0);
    idle(1);

    // Starvation: B head preempts after three A wins
    exp_wr(3, 32'hA0, 0); exp_wr(3, 32'hA1, 0); exp_wr(3, 32'hA2, 0);
    exp_wr(3, 32'hA3, 0); exp_wr(9, 32'hB9, 1); exp_wr(3, 32'hA4, 0);
    cyc(1, 3, 32'hA0, 1, 9, 32'hB9, 1, 1, "starve.k0");
    cyc(1, 3, 32'hA1, 0, 0, 0, 1, 1, "starve.k1");
    cyc(1, 3, 32'hA2, 0, 0, 0, 1, 1, "starve.k2");
    cyc(1, 3, 32'hA3, 0, 0, 0, 1, 1, "starve.k3");
    cyc(1, 3, 32'hA4, 0, 0, 0, 0, 1, "starve.k4");
    chk("starve.bwrite.src", 64'(bus.wb_src), 1);
    cyc(1, 3, 32'hA4, 0, 0, 0, 1, 1, "starve.k5");
    idle(2);

    // Full queue backpressure
    exp_wr(4, 32'h40, 0); exp_wr(4, 32'h41, 0); exp_wr(4, 32'h42, 0);
    exp_wr(4, 32'h43, 0); exp_wr(10, 32'hD0, 1); exp_wr(4, 32'h44, 0);
    exp_wr(11, 32'hD1, 1); exp_wr(12, 32'hD2, 1);
    cyc(1, 4, 32'h40, 1, 10, 32'hD0, 1, 1, "full.k0");
    cyc(1, 4, 32'h41, 1, 11, 32'hD1, 1, 1, "full.k1");
    chk("full.pending2", 64'(bus.pending), 64'h0C00);
    cyc(1, 4, 32'h42, 1, 12, 32'hD2, 1, 0, "full.k2");
    cyc(1, 4, 32'h43, 1, 12, 32'hD2, 1, 0, "full.k3");
    cyc(1, 4, 32'h44, 1, 12, 32'hD2, 0, 0, "full.k4");
    cyc(1, 4, 32'h44, 1, 12, 32'hD2, 1, 1, "full.k5");
    chk("full.pending6", 64'(bus.pending), 64'h1800);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, "full.k6");
    cyc(0, 0, 0, 0, 0, 0, 1, 1, "full.k7");
    idle(2);
    chk("full.drained.pending", 64'(bus.pending), 0);

    // Address 0 on both sides
    cyc(1, 0, 32'h55, 0, 0, 0, 1, 1, "a0.k0");
    chk("a0.regWrite", 64'(bus.regWrite), 0);
    cyc(0, 0, 0, 1, 0, 32'h66, 1, 1, "b0.k1");
    chk("b0.queued.pending", 64'(bus.pending), 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, "b0.k2");
    chk("b0.granted.regWrite", 64'(bus.regWrite), 0);
    chk("b0.granted.pending", 64'(bus.pending), 0);
    idle(1);

    // Reset mid-run with two B entries queued
    exp_wr(2, 32'h20, 0); exp_wr(2, 32'h21, 0);
    cyc(1, 2, 32'h20, 1, 20, 32'hE0, 1, 1, "mrst.k0");
    cyc(1, 2, 32'h21, 1, 21, 32'hE1, 1, 1, "mrst.k1");
    bus.a_data = 32'h22; bus.b_valid = 0;
    @(negedge clk);
    chk("mrst.pending", 64'(bus.pending), 64'h0030_0000);
    #2 rst = 0;
    #1;
    chk("mrst.regWrite", 64'(bus.regWrite), 0);
    chk("mrst.pending0", 64'(bus.pending), 0);
    chk("mrst.b_ready", 64'(bus.b_ready), 1);
    bus.b_valid = 1; bus.b_addr = 5'd22; bus.b_data = 32'hE2;
    repeat (2) @(posedge clk);
    #1;
    chk("mrst.held.pending", 64'(bus.pending), 0);
    bus.a_valid = 0; bus.b_valid = 0;
    rst = 1;
    idle(6);
    chk("mrst.after.pending", 64'(bus.pending), 0);

    chk("drain", 64'(expq.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: entries in the B-side pending queue; legal range 2..8.
REQ-002 Parameter STARVE_LIMIT, default 3: waiting cycles after which the B queue head preempts A; legal range 1..15.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock, shared with the register file.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 a_valid  input  1  ALU write-back request.
REQ-007 a_addr  input  5  ALU destination register.
REQ-008 a_data  input  32  ALU result.
REQ-009 a_ready  output  1  ALU request accepted this cycle when a_valid is high.
REQ-010 b_valid  input  1  load/mult-div write-back request.
REQ-011 b_addr  input  5  B destination register.
REQ-012 b_data  input  32  B result.
REQ-013 b_ready  output  1  B queue can accept an entry.
REQ-014 regWrite  output  1  register-file write enable (registered).
REQ-015 rWriteAddress  output  5  register-file write address (registered).
REQ-016 rWriteValue  output  32  register-file write data (registered).
REQ-017 wb_src  output  1  source of the current write: 0 = A, 1 = B.
REQ-018 pending  output  32  per-register flag: a B write to that register is queued or in the output stage.

Function
REQ-019 A B transfer SHALL occur on b_valid && b_ready; b_ready SHALL equal !full; entries SHALL leave the queue in FIFO order.
REQ-020 Simultaneous push and pop SHALL be legal when the queue is not full; count SHALL be unchanged.
REQ-021 age SHALL count the cycles the queue head has been present and not granted.
REQ-022 age SHALL reset to 0 on every pop and whenever the queue is empty, and SHALL saturate at STARVE_LIMIT.
REQ-023 Grant each cycle: B head SHALL win if the queue is non-empty and (age == STARVE_LIMIT or !a_valid); otherwise A SHALL win if a_valid.
REQ-024 a_ready SHALL be low exactly when the queue is non-empty and age == STARVE_LIMIT; it is combinational from state only, not from a_valid.
REQ-025 At most one write SHALL be issued per cycle; the winner SHALL be loaded into the output stage at the next rising edge.
REQ-026 Latency: an A grant in cycle N SHALL show regWrite=1 in cycle N+1.
REQ-027 Latency: a B entry accepted in cycle N SHALL be grant-eligible in N+1 and SHALL show regWrite=1 no earlier than N+2.
REQ-028 A granted request with address 0 SHALL be consumed, but the output stage SHALL load regWrite=0; address-0 B entries SHALL never set pending.
REQ-029 With no grant, the output stage SHALL load regWrite=0 and hold rWriteAddress, rWriteValue and wb_src.
REQ-030 pending[i] SHALL be 1 iff some queue entry has address i, or the output stage holds regWrite=1, wb_src=1, rWriteAddress=i; pending[0] SHALL always be 0.
REQ-031 pending SHALL be combinational from registered state.
REQ-032 Requests to the same register SHALL be written in grant order; the block SHALL NOT merge or reorder entries.
REQ-033 Inputs SHALL be ignored while rst is low.

Reset
REQ-034 On rst low, asynchronously: queue empty, age=0, regWrite=0, rWriteAddress=0, rWriteValue=0, wb_src=0.
REQ-035 While rst is low, the outputs SHALL read pending=0, b_ready=1 and a_ready=1.
REQ-036 Reset mid-operation SHALL discard all queued B entries without issuing their writes.
REQ-037 Normal operation SHALL resume on the first rising edge after rst is released.

Verification
REQ-038 A only: a_valid=1, a_addr=5, a_data=0x1234 at cycle 0 -> cycle 1 regWrite=1, rWriteAddress=5, rWriteValue=0x1234, wb_src=0.
REQ-039 B only: b_addr=7, b_data=0xCAFE accepted at cycle 0 -> pending[7]=1 from cycle 1; regWrite=1, wb_src=1 at cycle 2; pending[7]=0 at cycle 3.
REQ-040 Starvation, STARVE_LIMIT=3, a_valid held high, one B entry queued -> A wins 3 cycles, then a_ready=0 for 1 cycle and B is written.
REQ-041 Full queue, DEPTH=2, a_valid held high -> two B pushes, then b_ready=0; a third b_valid is not accepted until a pop occurs.
REQ-042 Address 0: a_addr=0 granted -> regWrite=0 next cycle, a_ready=1; b_addr=0 queued -> pending stays 0.
REQ-043 Reset mid-run: two B entries queued, rst pulsed low -> regWrite=0, pending=0 immediately; neither entry is ever written.
